// File: rtl/cache_axi_bridge_pkg.sv
// Shared encodings for the cache miss bridge: request types, AXI burst
// constants and the read/write FSM state types.
package cache_axi_bridge_pkg;

  localparam logic [2:0] RD_TYPE_BYTE      = 3'b000;
  localparam logic [2:0] RD_TYPE_HALF      = 3'b001;
  localparam logic [2:0] RD_TYPE_WORD      = 3'b010;
  localparam logic [2:0] RD_TYPE_CACHELINE = 3'b100;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  // AxLEN for a request: a full burst for a line, a single beat otherwise.
  function automatic logic [7:0] burst_len(input logic [2:0] req_type,
                                           input int unsigned beats);
    return (req_type == RD_TYPE_CACHELINE) ? 8'(beats - 1) : 8'd0;
  endfunction

  // AxSIZE for a request: word beats for a line, else the access size.
  function automatic logic [2:0] burst_size(input logic [2:0] req_type);
    return (req_type == RD_TYPE_CACHELINE) ? AXI_SIZE_4B : {1'b0, req_type[1:0]};
  endfunction

endpackage

// File: rtl/cache_wbuf.sv
// Write line buffer: holds a cache line and presents it one 32-bit word at a
// time, counting beats so the final beat of the burst can be flagged.
module cache_wbuf #(
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] data,
  input  logic                  shift,
  input  logic [7:0]            len,
  output logic [31:0]           word,
  output logic                  last
);

  logic [LINE_WIDTH-1:0] line_q;
  logic [7:0]            cnt_q;

  // Load a fresh line (counter back to 0) or step to the next word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      line_q <= data;
      cnt_q  <= '0;
    end else if (shift) begin
      line_q <= line_q >> 32;
      cnt_q  <= cnt_q + 8'd1;
    end
  end

  assign word = line_q[31:0];
  assign last = (cnt_q == len);

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache miss interface to AXI4 bridge: one read (AR/R) and one write
// (AW/W/B) transaction in flight at most, with reads returned word by word.
import cache_axi_bridge_pkg::*;

module cache_axi_bridge #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter logic [3:0]  RD_ID      = 4'd0,
  parameter logic [3:0]  WR_ID      = 4'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  // cache read side
  input  logic                  rd_req,
  input  logic [2:0]            rd_type,
  input  logic [31:0]           rd_addr,
  output logic                  rd_rdy,
  output logic                  ret_valid,
  output logic                  ret_last,
  output logic [31:0]           ret_data,
  // cache write side
  input  logic                  wr_req,
  input  logic [2:0]            wr_type,
  input  logic [31:0]           wr_addr,
  input  logic [3:0]            wr_wstrb,
  input  logic [LINE_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  // AXI AR
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI R
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI AW
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI W
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI B
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int unsigned BEATS = LINE_WIDTH / 32;

  rd_state_t   rd_state;
  wr_state_t   wr_state;
  logic [31:0] rd_addr_q;
  logic [2:0]  rd_type_q;
  logic [31:0] wr_addr_q;
  logic [2:0]  wr_type_q;
  logic [3:0]  wr_wstrb_q;
  logic        both_idle;
  logic        wr_accept;
  logic        buf_last;
  logic [31:0] buf_word;

  // Response IDs and status codes carry nothing this bridge acts on.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  // A write presented alongside a read while idle takes priority, so that
  // pending stores reach memory before a refill can read the same line.
  assign both_idle = (rd_state == R_IDLE) && (wr_state == W_IDLE);
  assign wr_rdy    = both_idle;
  assign rd_rdy    = both_idle && !wr_req;
  assign wr_accept = wr_req && wr_rdy;

  // Read FSM: latch the request, issue AR, then stream R beats back.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state  <= R_IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rd_addr_q <= '0;
      rd_type_q <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (rd_req && rd_rdy) begin
          rd_addr_q <= rd_addr;
          rd_type_q <= rd_type;
          arvalid   <= 1'b1;
          rd_state  <= R_AR;
        end
        R_AR: if (arready) begin
          arvalid  <= 1'b0;
          rready   <= 1'b1;
          rd_state <= R_DATA;
        end
        R_DATA: if (rvalid && rlast) begin
          rready   <= 1'b0;
          rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign arid      = RD_ID;
  assign araddr    = rd_addr_q;
  assign arlen     = burst_len(rd_type_q, BEATS);
  assign arsize    = burst_size(rd_type_q);
  assign arburst   = AXI_BURST_INCR;
  assign ret_valid = rready && rvalid;
  assign ret_last  = rready && rlast;
  assign ret_data  = rdata;

  // Write FSM: latch the request, issue AW, drain the line buffer on W,
  // then wait for the B response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state   <= W_IDLE;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      wr_addr_q  <= '0;
      wr_type_q  <= '0;
      wr_wstrb_q <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (wr_accept) begin
          wr_addr_q  <= wr_addr;
          wr_type_q  <= wr_type;
          wr_wstrb_q <= wr_wstrb;
          awvalid    <= 1'b1;
          wr_state   <= W_AW;
        end
        W_AW: if (awready) begin
          awvalid  <= 1'b0;
          wvalid   <= 1'b1;
          wr_state <= W_DATA;
        end
        W_DATA: if (wready && buf_last) begin
          wvalid   <= 1'b0;
          bready   <= 1'b1;
          wr_state <= W_RESP;
        end
        W_RESP: if (bvalid) begin
          bready   <= 1'b0;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  cache_wbuf #(
    .LINE_WIDTH (LINE_WIDTH)
  ) u_wbuf (
    .clk    (clk),
    .resetn (resetn),
    .load   (wr_accept),
    .data   (wr_data),
    .shift  (wvalid && wready),
    .len    (awlen),
    .word   (buf_word),
    .last   (buf_last)
  );

  assign awid    = WR_ID;
  assign awaddr  = wr_addr_q;
  assign awlen   = burst_len(wr_type_q, BEATS);
  assign awsize  = burst_size(wr_type_q);
  assign awburst = AXI_BURST_INCR;
  assign wdata   = buf_word;
  assign wstrb   = (wr_type_q == RD_TYPE_CACHELINE) ? 4'hf : wr_wstrb_q;
  assign wlast   = wvalid && buf_last;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: line/word reads, line/byte writes,
// write-over-read priority, reset mid-burst, plus AXI valid/payload hold checks.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = '0;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = '0;
  logic [31:0]  wr_addr = '0;
  logic [3:0]   wr_wstrb = '0;
  logic [255:0] wr_data = '0;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [3:0]   rid = '0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [3:0]   bid = '0;
  logic [1:0]   bresp = '0;
  logic         bvalid = 1'b0;
  logic         bready;

  int n_cmp = 0;
  int n_err = 0;

  cache_axi_bridge #(
    .LINE_WIDTH (256),
    .RD_ID      (4'd0),
    .WR_ID      (4'd1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Valid/payload hold: once a valid is seen without its ready, the next
  // cycle must present the same valid and payload.
  logic        p_ok = 1'b0;
  logic        p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [7:0]  p_arlen, p_awlen;
  logic [3:0]  p_wstrb;
  logic        p_wlast;

  always @(negedge clk) begin
    if (p_ok && resetn) begin
      if (p_ar) begin
        chk("ar_hold_valid", 64'(arvalid), 64'd1);
        chk("ar_hold_addr", {24'd0, p_arlen, araddr}, {24'd0, arlen, p_araddr});
      end
      if (p_aw) begin
        chk("aw_hold_valid", 64'(awvalid), 64'd1);
        chk("aw_hold_addr", {24'd0, p_awlen, awaddr}, {24'd0, awlen, p_awaddr});
      end
      if (p_w) begin
        chk("w_hold_valid", 64'(wvalid), 64'd1);
        chk("w_hold_data", {27'd0, wlast, wstrb, wdata}, {27'd0, p_wlast, p_wstrb, p_wdata});
      end
      if (wvalid) chk("w_after_aw", 64'(awvalid), 64'd0);
    end
    p_ok     = resetn;
    p_ar     = arvalid && !arready;
    p_aw     = awvalid && !awready;
    p_w      = wvalid && !wready;
    p_araddr = araddr;
    p_arlen  = arlen;
    p_awaddr = awaddr;
    p_awlen  = awlen;
    p_wdata  = wdata;
    p_wstrb  = wstrb;
    p_wlast  = wlast;
  end

  logic [255:0] line;
  int           k;

  initial begin
    // ---------------- reset ----------------
    cyc(); cyc();
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_ret_valid", 64'(ret_valid), 64'd0);
    chk("rst_rd_rdy", 64'(rd_rdy), 64'd1);
    chk("rst_wr_rdy", 64'(wr_rdy), 64'd1);
    resetn = 1'b1;

    // ---------------- line read, gapped beats ----------------
    cyc();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C000040;
    #1 chk("lr_accept", 64'(rd_rdy), 64'd1);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("lr_arvalid", 64'(arvalid), 64'd1);
    chk("lr_araddr", 64'(araddr), 64'h1C000040);
    chk("lr_arlen", 64'(arlen), 64'd7);
    chk("lr_arsize", 64'(arsize), 64'd2);
    chk("lr_arburst", 64'(arburst), 64'd1);
    chk("lr_arid", 64'(arid), 64'd0);
    chk("lr_busy", 64'(rd_rdy), 64'd0);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    #1;
    chk("lr_ar_drop", 64'(arvalid), 64'd0);
    chk("lr_rready", 64'(rready), 64'd1);
    for (int b = 0; b < 8; b++) begin
      if (b == 3 || b == 5) begin
        rvalid = 1'b0; rlast = 1'b0;
        #1 chk("lr_gap", 64'(ret_valid), 64'd0);
        cyc();
      end
      rvalid = 1'b1; rdata = 32'hA0 + 32'(b); rlast = (b == 7);
      #1;
      chk("lr_ret_valid", 64'(ret_valid), 64'd1);
      chk("lr_ret_data", 64'(ret_data), 64'hA0 + 64'(b));
      chk("lr_ret_last", 64'(ret_last), (b == 7) ? 64'd1 : 64'd0);
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("lr_done_rdy", 64'(rd_rdy), 64'd1);
    chk("lr_done_rready", 64'(rready), 64'd0);

    // ---------------- word read, delayed arready ----------------
    cyc();
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'hBFAF8000;
    #1 chk("wr_rd_accept", 64'(rd_rdy), 64'd1);
    cyc();
    rd_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      arready = (c == 3);
      #1;
      chk("wd_arvalid", 64'(arvalid), 64'd1);
      chk("wd_araddr", 64'(araddr), 64'hBFAF8000);
      chk("wd_arlen", 64'(arlen), 64'd0);
      chk("wd_arsize", 64'(arsize), 64'd2);
      cyc();
    end
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEADBEEF;
    #1;
    chk("wd_ar_drop", 64'(arvalid), 64'd0);
    chk("wd_ret_valid", 64'(ret_valid), 64'd1);
    chk("wd_ret_data", 64'(ret_data), 64'hDEADBEEF);
    chk("wd_ret_last", 64'(ret_last), 64'd1);
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("wd_done_rdy", 64'(rd_rdy), 64'd1);

    // ---------------- line write, toggling wready ----------------
    cyc();
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = 32'h11111111 * 32'(i);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1C000080; wr_wstrb = 4'h0;
    wr_data = line;
    #1;
    chk("lw_accept", 64'(wr_rdy), 64'd1);
    chk("lw_rd_blocked", 64'(rd_rdy), 64'd0);
    cyc();
    wr_req = 1'b0; wr_data = '0;
    #1;
    chk("lw_awvalid", 64'(awvalid), 64'd1);
    chk("lw_awaddr", 64'(awaddr), 64'h1C000080);
    chk("lw_awlen", 64'(awlen), 64'd7);
    chk("lw_awsize", 64'(awsize), 64'd2);
    chk("lw_awburst", 64'(awburst), 64'd1);
    chk("lw_awid", 64'(awid), 64'd1);
    chk("lw_no_wvalid", 64'(wvalid), 64'd0);
    awready = 1'b1;
    cyc();
    awready = 1'b0;
    k = 0;
    for (int s = 0; s < 16; s++) begin
      wready = (s % 2 == 1);
      #1;
      chk("lw_wvalid", 64'(wvalid), 64'd1);
      chk("lw_wdata", 64'(wdata), 64'(32'h11111111 * 32'(k)));
      chk("lw_wstrb", 64'(wstrb), 64'hf);
      chk("lw_wlast", 64'(wlast), (k == 7) ? 64'd1 : 64'd0);
      if (wready) k++;
      cyc();
    end
    wready = 1'b0;
    #1;
    chk("lw_bready", 64'(bready), 64'd1);
    chk("lw_w_drop", 64'(wvalid), 64'd0);
    chk("lw_busy", 64'(wr_rdy), 64'd0);
    cyc();
    bvalid = 1'b1;
    #1 chk("lw_bready2", 64'(bready), 64'd1);
    cyc();
    bvalid = 1'b0;
    #1;
    chk("lw_done_rdy", 64'(wr_rdy), 64'd1);
    chk("lw_done_bready", 64'(bready), 64'd0);

    // ---------------- byte write ----------------
    cyc();
    wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h1C0000A3; wr_wstrb = 4'b1000;
    wr_data = '0; wr_data[31:0] = 32'hCC000000;
    #1 chk("bw_accept", 64'(wr_rdy), 64'd1);
    cyc();
    wr_req = 1'b0;
    awready = 1'b1;
    #1;
    chk("bw_awaddr", 64'(awaddr), 64'h1C0000A3);
    chk("bw_awsize", 64'(awsize), 64'd0);
    chk("bw_awlen", 64'(awlen), 64'd0);
    cyc();
    awready = 1'b0;
    wready = 1'b1;
    #1;
    chk("bw_wvalid", 64'(wvalid), 64'd1);
    chk("bw_wstrb", 64'(wstrb), 64'h8);
    chk("bw_wlast", 64'(wlast), 64'd1);
    chk("bw_wdata", 64'(wdata), 64'hCC000000);
    cyc();
    wready = 1'b0;
    bvalid = 1'b1;
    #1 chk("bw_bready", 64'(bready), 64'd1);
    cyc();
    bvalid = 1'b0;
    #1 chk("bw_done_rdy", 64'(wr_rdy), 64'd1);

    // ---------------- simultaneous read and write ----------------
    cyc();
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h00002000;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h00003000; wr_wstrb = 4'hf;
    wr_data = '0; wr_data[31:0] = 32'h5A5A5A5A;
    #1;
    chk("sim_wr_rdy", 64'(wr_rdy), 64'd1);
    chk("sim_rd_rdy", 64'(rd_rdy), 64'd0);
    cyc();
    wr_req = 1'b0;
    #1;
    chk("sim_awvalid", 64'(awvalid), 64'd1);
    chk("sim_no_ar", 64'(arvalid), 64'd0);
    chk("sim_rd_wait1", 64'(rd_rdy), 64'd0);
    awready = 1'b1;
    cyc();
    awready = 1'b0;
    wready = 1'b1;
    #1;
    chk("sim_wdata", 64'(wdata), 64'h5A5A5A5A);
    chk("sim_rd_wait2", 64'(rd_rdy), 64'd0);
    cyc();
    wready = 1'b0;
    bvalid = 1'b1;
    #1 chk("sim_rd_wait3", 64'(rd_rdy), 64'd0);
    cyc();
    bvalid = 1'b0;
    #1 chk("sim_rd_now", 64'(rd_rdy), 64'd1);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("sim_arvalid", 64'(arvalid), 64'd1);
    chk("sim_araddr", 64'(araddr), 64'h00002000);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h13572468;
    #1 chk("sim_ret", {31'd0, ret_valid, ret_data}, {31'd0, 1'b1, 32'h13572468});
    cyc();
    rvalid = 1'b0; rlast = 1'b0;

    // ---------------- reset during read burst ----------------
    cyc();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C000040;
    cyc();
    rd_req = 1'b0;
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rdata = 32'hA0 + 32'(b); rlast = 1'b0;
      cyc();
    end
    rvalid = 1'b1; rdata = 32'hA4; resetn = 1'b0;
    cyc();
    resetn = 1'b1; rvalid = 1'b0;
    #1;
    chk("mr_arvalid", 64'(arvalid), 64'd0);
    chk("mr_rready", 64'(rready), 64'd0);
    chk("mr_awvalid", 64'(awvalid), 64'd0);
    chk("mr_wvalid", 64'(wvalid), 64'd0);
    chk("mr_bready", 64'(bready), 64'd0);
    chk("mr_ret_valid", 64'(ret_valid), 64'd0);
    chk("mr_rd_rdy", 64'(rd_rdy), 64'd1);
    chk("mr_wr_rdy", 64'(wr_rdy), 64'd1);
    cyc();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C000100;
    #1 chk("mr2_accept", 64'(rd_rdy), 64'd1);
    cyc();
    rd_req = 1'b0;
    arready = 1'b1;
    #1 chk("mr2_araddr", {24'd0, arlen, araddr}, {24'd0, 8'd7, 32'h1C000100});
    cyc();
    arready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      rvalid = 1'b1; rdata = 32'hB0 + 32'(b); rlast = (b == 7);
      #1 chk("mr2_beat", {30'd0, ret_valid, ret_last, ret_data},
                         {30'd0, 1'b1, (b == 7), 32'hB0 + 32'(b)});
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("mr2_done_rdy", 64'(rd_rdy), 64'd1);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
